// File: rtl/fpu_cvt_pkg.sv
// Shared types and constants for the float32 -> int32/uint32 conversion pipeline.
package fpu_cvt_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned EXP_TINY = 124;
  localparam int unsigned EXP_BIG  = 159;

  localparam logic [DATA_W-1:0] INT32_MAX  = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] INT32_MIN  = 32'h8000_0000;
  localparam logic [DATA_W-1:0] UINT32_MAX = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } rm_e;

  typedef enum logic [2:0] {
    NORM = 3'd0,
    TINY = 3'd1,
    BIG  = 3'd2,
    INF  = 3'd3,
    NAN  = 3'd4
  } cls_e;

  typedef struct packed {
    logic nv;
    logic nx;
  } cvt_flags_t;

  // S1 payload; rm is kept raw so reserved encodings reach the rounder.
  typedef struct packed {
    logic              sign;
    logic [DATA_W-1:0] int32;
    logic              g;
    logic              r;
    logic              s;
    cls_e              cls;
    logic              is_signed;
    logic [2:0]        rm;
  } s1_t;

endpackage

// File: rtl/fpu_cvt_round.sv
// Combinational S2: rounding increment, range check, saturation and {NV, NX} generation.
module fpu_cvt_round
  import fpu_cvt_pkg::*;
(
  input  s1_t               op,
  output logic [DATA_W-1:0] data,
  output cvt_flags_t        flags
);

  logic              inc;
  logic              inexact;
  logic              ok;
  logic [DATA_W:0]   mag;
  logic [DATA_W-1:0] sat;

  always_comb begin
    inc     = 1'b0;
    inexact = op.g | op.r | op.s;
    case (op.rm)
      RNE:     inc = op.g & (op.r | op.s | op.int32[0]);
      RTZ:     inc = 1'b0;
      RDN:     inc = op.sign & inexact;
      RUP:     inc = ~op.sign & inexact;
      RMM:     inc = op.g;
      default: inc = 1'b0;
    endcase

    mag = {1'b0, op.int32} + (DATA_W+1)'(inc);

    if (op.is_signed) begin
      ok = op.sign ? (mag <= {1'b0, INT32_MIN}) : (mag <= {1'b0, INT32_MAX});
    end else begin
      ok = ~mag[DATA_W] & ~(op.sign & (mag != '0));
    end

    if (op.is_signed) sat = op.sign ? INT32_MIN : INT32_MAX;
    else              sat = op.sign ? '0 : UINT32_MAX;

    data  = '0;
    flags = '0;
    if (op.rm > 3'(RMM)) begin
      flags.nv = 1'b1;
    end else if (op.cls == NAN) begin
      data     = op.is_signed ? INT32_MAX : UINT32_MAX;
      flags.nv = 1'b1;
    end else if ((op.cls == BIG) || (op.cls == INF) || !ok) begin
      data     = sat;
      flags.nv = 1'b1;
    end else begin
      // Unsigned negatives only get here with mag==0, so negation still yields 0.
      data     = op.sign ? DATA_W'(-mag) : mag[DATA_W-1:0];
      flags.nx = inexact;
    end
  end

endmodule

// File: rtl/fpu_flt2int.sv
// Float-to-fixed shifter: aligns the significand to an integer with guard, round and sticky bits.
// Output is meaningful only for biased exponents 124..158.
module fpu_flt2int (
  input  logic [30:0] operand,
  output logic [34:0] fixed
);

  logic [5:0]  sh;
  logic [57:0] wide;

  // exp 158 places the hidden bit at integer bit 31; 34 spare bits keep every shifted-out bit.
  assign sh    = 6'(8'd158 - operand[30:23]);
  assign wide  = {1'b1, operand[22:0], 34'd0} >> sh;
  assign fixed = {wide[57:26], wide[25], wide[24], |wide[23:0]};

endmodule

// File: rtl/fpu_cvt_ctrl.sv
// FCVT.W.S / FCVT.WU.S controller: classify+shift (S1), round+saturate into the output register (S2).
// The whole pipe freezes while the output is held; flush kills S1 and the output register.
module fpu_cvt_ctrl
  import fpu_cvt_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_signed,
  input  logic [2:0]        in_rm,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_flags,
  output logic [TAG_W-1:0]  out_tag
);

  logic              stall;
  logic              accept;
  logic [7:0]        exp_f;
  logic [22:0]       mant_f;
  logic [34:0]       fixed;
  s1_t               s1_d;
  s1_t               s1_q;
  logic              s1_valid;
  logic [TAG_W-1:0]  s1_tag;
  logic [DATA_W-1:0] rnd_data;
  cvt_flags_t        rnd_flags;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready & ~flush;
  assign exp_f    = in_data[30:23];
  assign mant_f   = in_data[22:0];

  fpu_flt2int u_flt2int (
    .operand (in_data[30:0]),
    .fixed   (fixed)
  );

  // Classification; the shifter result is overridden for out-of-window exponents.
  always_comb begin
    s1_d.sign      = in_data[31];
    s1_d.is_signed = in_signed;
    s1_d.rm        = in_rm;
    s1_d.int32     = fixed[34:3];
    s1_d.g         = fixed[2];
    s1_d.r         = fixed[1];
    s1_d.s         = fixed[0];
    s1_d.cls       = NORM;
    if (exp_f == 8'd255) begin
      s1_d.cls = (mant_f != '0) ? NAN : INF;
    end else if (exp_f >= 8'(EXP_BIG)) begin
      s1_d.cls = BIG;
    end else if (exp_f < 8'(EXP_TINY)) begin
      s1_d.cls   = TINY;
      s1_d.int32 = '0;
      s1_d.g     = 1'b0;
      s1_d.r     = 1'b0;
      s1_d.s     = |in_data[30:0];
    end
  end

  fpu_cvt_round u_round (
    .op    (s1_q),
    .data  (rnd_data),
    .flags (rnd_flags)
  );

  // Pipeline registers: reset > flush > stall freeze > advance.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_q      <= '0;
      s1_tag    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
      out_tag   <= '0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_q   <= s1_d;
        s1_tag <= in_tag;
      end
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data  <= rnd_data;
        out_flags <= rnd_flags;
        out_tag   <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_fpu_cvt_ctrl.sv
// Self-checking bench for fpu_cvt_ctrl: directed vectors, backpressure, flush, reset and random traffic.
module tb_fpu_cvt_ctrl;

  localparam int unsigned TAG_W = 5;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = '0;
  logic             in_signed = 1'b0;
  logic [2:0]       in_rm = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_data;
  logic [1:0]       out_flags;
  logic [TAG_W-1:0] out_tag;

  typedef struct {
    logic [31:0]      data;
    logic [1:0]       flags;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t             expq[$];
  int               checks = 0;
  int               failures = 0;
  logic [TAG_W-1:0] next_tag = '0;

  always #5 clock = ~clock;

  fpu_cvt_ctrl #(.TAG_W(TAG_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_signed (in_signed),
    .in_rm     (in_rm),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags),
    .out_tag   (out_tag)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: exact value m*2^(e-150), rounded by comparing the dropped remainder to one half.
  function automatic logic [33:0] ref_cvt(input logic [31:0] f, input logic sg, input logic [2:0] rm);
    logic   neg, gt, eq, nz, up, inr;
    int     e, sh;
    longint m, q, rem, half, mag, v;
    neg = f[31];
    e   = int'(f[30:23]);
    m   = longint'(f[22:0]);
    gt = 1'b0; eq = 1'b0; nz = 1'b0; q = 0;
    if (rm > 3'd4) return {32'd0, 2'b10};
    if (e == 255 && m != 0) return {(sg ? 32'h7FFF_FFFF : 32'hFFFF_FFFF), 2'b10};
    if (e == 255) begin
      q = longint'(1) << 40;
    end else begin
      if (e != 0) m = m + (longint'(1) << 23);
      else        e = 1;
      sh = 150 - e;
      if (sh <= 0) begin
        q = (-sh > 16) ? (longint'(1) << 40) : (m << (-sh));
      end else if (sh >= 40) begin
        q  = 0;
        nz = (m != 0);
      end else begin
        q    = m >> sh;
        rem  = m & ((longint'(1) << sh) - 1);
        half = longint'(1) << (sh - 1);
        gt   = rem > half;
        eq   = rem == half;
        nz   = rem != 0;
      end
    end
    case (rm)
      3'd0:    up = gt | (eq & q[0]);
      3'd2:    up = neg & nz;
      3'd3:    up = ~neg & nz;
      3'd4:    up = gt | eq;
      default: up = 1'b0;
    endcase
    mag = q + longint'(up);
    v   = neg ? -mag : mag;
    if (sg) inr = (v >= -(longint'(1) << 31)) && (v <= (longint'(1) << 31) - 1);
    else    inr = (v >= 0) && (v <= (longint'(1) << 32) - 1);
    if (inr) return {v[31:0], 1'b0, nz};
    if (sg) return {(neg ? 32'h8000_0000 : 32'h7FFF_FFFF), 2'b10};
    return {(neg ? 32'h0 : 32'hFFFF_FFFF), 2'b10};
  endfunction

  function automatic logic [31:0] rand_float();
    logic [31:0] f;
    f = $urandom;
    case ($urandom_range(0, 9))
      0:       f[30:23] = 8'd255;
      1:       f[30:23] = 8'($urandom_range(0, 3));
      default: f[30:23] = 8'($urandom_range(110, 165));
    endcase
    return f;
  endfunction

  // Called just after a negedge with inputs applied; covers the next posedge and returns at the following negedge.
  task automatic tick(input logic use_dir, input logic [33:0] dir, output logic acc);
    exp_t             e;
    logic             hold;
    logic [31:0]      h_data;
    logic [1:0]       h_flags;
    logic [TAG_W-1:0] h_tag;
    logic [33:0]      r;
    #1;
    acc = 1'b0;
    if (!reset) chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
    if (!reset && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        chk("unexpected_out", 64'(out_tag), 64'hFFFF);
      end else begin
        e = expq.pop_front();
        chk("out_tag", 64'(out_tag), 64'(e.tag));
        chk("out_data", 64'(out_data), 64'(e.data));
        chk("out_flags", 64'(out_flags), 64'(e.flags));
      end
    end
    if (reset || flush) expq.delete();
    if (!reset && !flush && in_valid && in_ready) begin
      acc = 1'b1;
      r = use_dir ? dir : ref_cvt(in_data, in_signed, in_rm);
      e.data = r[33:2]; e.flags = r[1:0]; e.tag = in_tag;
      expq.push_back(e);
    end
    hold    = !reset && !flush && out_valid && !out_ready;
    h_data  = out_data;
    h_flags = out_flags;
    h_tag   = out_tag;
    @(negedge clock);
    if (hold) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", 64'(out_data), 64'(h_data));
      chk("hold_flags", 64'(out_flags), 64'(h_flags));
      chk("hold_tag", 64'(out_tag), 64'(h_tag));
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick(1'b0, '0, acc);
  endtask

  task automatic send_dir(input logic [31:0] f, input logic sg, input logic [2:0] rm,
                          input logic [31:0] d, input logic [1:0] fl);
    logic acc;
    in_valid = 1'b1; in_data = f; in_signed = sg; in_rm = rm; in_tag = next_tag;
    out_ready = 1'b1;
    tick(1'b1, {d, fl}, acc);
    chk("dir_accept", 64'(acc), 64'd1);
    next_tag = next_tag + 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic acc;
    int   n;
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    n = 0;
    while ((expq.size() != 0 || out_valid) && n < 20) begin
      tick(1'b0, '0, acc);
      n++;
    end
    chk("drain_empty", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    logic acc;
    int   t, held, guard;

    @(negedge clock);
    idle(2);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_flags", 64'(out_flags), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Latency: accept at N, S1 at N+1, out_valid at N+2.
    in_valid = 1'b1; in_data = 32'h4049_0FDB; in_signed = 1'b1; in_rm = 3'd0; in_tag = 5'd7;
    tick(1'b1, {32'h0000_0003, 2'b01}, acc);
    chk("lat_accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
    chk("lat_n1", 64'(out_valid), 64'd0);
    tick(1'b0, '0, acc);
    chk("lat_n2", 64'(out_valid), 64'd1);
    drain();

    send_dir(32'h4020_0000, 1'b1, 3'd0, 32'h0000_0002, 2'b01);
    send_dir(32'h4020_0000, 1'b1, 3'd4, 32'h0000_0003, 2'b01);
    send_dir(32'h4020_0000, 1'b1, 3'd3, 32'h0000_0003, 2'b01);
    send_dir(32'h4020_0000, 1'b1, 3'd1, 32'h0000_0002, 2'b01);
    send_dir(32'hBFC0_0000, 1'b1, 3'd2, 32'hFFFF_FFFE, 2'b01);
    send_dir(32'hCF00_0000, 1'b1, 3'd0, 32'h8000_0000, 2'b00);
    send_dir(32'h4F00_0000, 1'b1, 3'd0, 32'h7FFF_FFFF, 2'b10);
    send_dir(32'h4F00_0000, 1'b0, 3'd0, 32'h8000_0000, 2'b00);
    send_dir(32'h4F80_0000, 1'b0, 3'd0, 32'hFFFF_FFFF, 2'b10);
    send_dir(32'h7FC0_0000, 1'b1, 3'd0, 32'h7FFF_FFFF, 2'b10);
    send_dir(32'h7FC0_0000, 1'b0, 3'd0, 32'hFFFF_FFFF, 2'b10);
    send_dir(32'hFF80_0000, 1'b0, 3'd0, 32'h0000_0000, 2'b10);
    send_dir(32'hBE99_999A, 1'b0, 3'd1, 32'h0000_0000, 2'b01);
    send_dir(32'hBE99_999A, 1'b0, 3'd2, 32'h0000_0000, 2'b10);
    send_dir(32'h8000_0000, 1'b0, 3'd0, 32'h0000_0000, 2'b00);
    send_dir(32'h4020_0000, 1'b1, 3'd5, 32'h0000_0000, 2'b10);
    drain();

    // Backpressure: tags 1..4 back to back, output held for 3 cycles.
    held = 0; t = 1; guard = 0;
    while (t <= 4 && guard < 30) begin
      in_valid = 1'b1; in_data = rand_float(); in_signed = 1'($urandom);
      in_rm = 3'($urandom_range(0, 4)); in_tag = TAG_W'(t);
      if (out_valid && held < 3) begin
        out_ready = 1'b0;
        held++;
      end else begin
        out_ready = 1'b1;
      end
      tick(1'b0, '0, acc);
      if (acc) t++;
      guard++;
    end
    chk("bp_all_sent", 64'(t), 64'd5);
    drain();

    // Flush with S1 and output both valid; a request offered alongside is dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 32'h4020_0000; in_signed = 1'b1; in_rm = 3'd0; in_tag = TAG_W'(20 + i);
      tick(1'b0, '0, acc);
    end
    chk("fl_pre_out", 64'(out_valid), 64'd1);
    flush = 1'b1; in_tag = 5'd22;
    tick(1'b0, '0, acc);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    tick(1'b0, '0, acc);
    chk("fl_s1_killed", 64'(out_valid), 64'd0);
    send_dir(32'h4049_0FDB, 1'b1, 3'd0, 32'h0000_0003, 2'b01);
    drain();

    // Reset mid-stream discards everything in flight.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 32'h4020_0000; in_signed = 1'b0; in_rm = 3'd3; in_tag = TAG_W'(25 + i);
      tick(1'b0, '0, acc);
    end
    reset = 1'b1; in_valid = 1'b0;
    tick(1'b0, '0, acc);
    chk("rs_out_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;
    idle(4);
    chk("rs_nothing_out", 64'(out_valid), 64'd0);
    chk("rs_in_ready", 64'(in_ready), 64'd1);

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = rand_float();
      in_signed = 1'($urandom);
      in_rm     = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      in_tag    = TAG_W'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      tick(1'b0, '0, acc);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
